// File: rtl/dpe_egress_peer_nonce.sv
// Egress nonce stage: looks up a per-peer receiver index and transmit counter by tid,
// attaches them as sideband, post-increments the counter, and drops disabled/exhausted peers.
module dpe_egress_peer_nonce #(
  parameter int unsigned NUM_PEERS    = 256,
  parameter logic [63:0] REJECT_AFTER = 64'hFFFF_FFFF_FFFF_DFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [127:0] s_axis_tdata,
  input  logic [15:0]  s_axis_tkeep,
  input  logic         s_axis_tlast,
  input  logic [7:0]   s_axis_tid,
  input  logic [2:0]   s_axis_tuser_dst,
  input  logic [2:0]   s_axis_tuser_src,
  input  logic         s_axis_tuser_bypass_all,
  input  logic         s_axis_tuser_bypass_stage,
  output logic         m_axis_tvalid,
  input  logic         m_axis_tready,
  output logic [127:0] m_axis_tdata,
  output logic [15:0]  m_axis_tkeep,
  output logic         m_axis_tlast,
  output logic [7:0]   m_axis_tid,
  output logic [2:0]   m_axis_tuser_dst,
  output logic [2:0]   m_axis_tuser_src,
  output logic         m_axis_tuser_bypass_all,
  output logic         m_axis_tuser_bypass_stage,
  output logic [63:0]  m_axis_tuser_nonce,
  output logic [31:0]  m_axis_tuser_rx_idx,
  input  logic         cfg_we,
  input  logic [7:0]   cfg_peer,
  input  logic [31:0]  cfg_rx_idx,
  input  logic         cfg_en,
  output logic         cfg_ack,
  output logic [31:0]  stat_drop_cnt
);

  localparam int unsigned AW = $clog2(NUM_PEERS);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_FWD, S_DROP} state_t;

  state_t            state, state_nxt;

  logic [63:0]       ctr_mem [NUM_PEERS];
  logic [31:0]       rx_mem  [NUM_PEERS];
  logic [NUM_PEERS-1:0] en_vec;

  logic              rd_en;
  logic [63:0]       rd_ctr;
  logic [31:0]       rd_rx;

  logic              pend;
  logic [7:0]        pend_peer;
  logic [31:0]       pend_rx;
  logic              pend_en;

  logic              wr_en;
  logic [7:0]        wr_peer;
  logic [63:0]       wr_ctr;
  logic [31:0]       wr_rx;
  logic              wr_ven;

  logic              cfg_fire;
  logic              start;
  logic              byp;
  logic              reject;
  logic              tid_ok;

  assign cfg_fire = (state == S_IDLE) && (pend || cfg_we);
  assign start    = (state == S_IDLE) && !(pend || cfg_we) && s_axis_tvalid;
  assign byp      = m_axis_tuser_bypass_all || m_axis_tuser_bypass_stage;
  assign reject   = !rd_en || (rd_ctr >= REJECT_AFTER);
  assign tid_ok   = 32'(s_axis_tid) < NUM_PEERS;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOOKUP;
      S_LOOKUP: state_nxt = (!byp && reject) ? S_DROP : S_FWD;
      S_FWD:    if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_nxt = S_IDLE;
      S_DROP:   if (s_axis_tvalid && s_axis_tlast) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Stream outputs: combinational pass-through while forwarding, drain while dropping
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    if (state == S_FWD) begin
      s_axis_tready = m_axis_tready;
      m_axis_tvalid = s_axis_tvalid;
      m_axis_tdata  = s_axis_tdata;
      m_axis_tkeep  = s_axis_tkeep;
      m_axis_tlast  = s_axis_tlast;
    end else if (state == S_DROP) begin
      s_axis_tready = 1'b1;
    end
  end

  // Single context write port: config writes in IDLE, counter writeback in LOOKUP
  always_comb begin
    wr_en   = 1'b0;
    wr_peer = '0;
    wr_ctr  = '0;
    wr_rx   = '0;
    wr_ven  = 1'b0;
    if (state == S_IDLE && pend) begin
      wr_en = 1'b1; wr_peer = pend_peer; wr_rx = pend_rx; wr_ven = pend_en;
    end else if (state == S_IDLE && cfg_we) begin
      wr_en = 1'b1; wr_peer = cfg_peer; wr_rx = cfg_rx_idx; wr_ven = cfg_en;
    end else if (state == S_LOOKUP && !byp && !reject) begin
      wr_en = 1'b1; wr_peer = m_axis_tid; wr_rx = rd_rx; wr_ven = 1'b1;
      wr_ctr = rd_ctr + 64'd1;
    end
    if (32'(wr_peer) >= NUM_PEERS) wr_en = 1'b0;
  end

  // Context RAM payload (enable bits live in resettable flops)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ctr_mem[wr_peer[AW-1:0]] <= wr_ctr;
      rx_mem[wr_peer[AW-1:0]]  <= wr_rx;
    end
  end

  // Peer enables; cleared on reset so every peer starts disabled
  always_ff @(posedge clk) begin
    if (rst)        en_vec <= '0;
    else if (wr_en) en_vec[wr_peer[AW-1:0]] <= wr_ven;
  end

  // Sideband capture, synchronous context read, and nonce/rx_idx assignment
  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tid                <= '0;
      m_axis_tuser_dst          <= '0;
      m_axis_tuser_src          <= '0;
      m_axis_tuser_bypass_all   <= 1'b0;
      m_axis_tuser_bypass_stage <= 1'b0;
      m_axis_tuser_nonce        <= '0;
      m_axis_tuser_rx_idx       <= '0;
      rd_en                     <= 1'b0;
      rd_ctr                    <= '0;
      rd_rx                     <= '0;
    end else if (start) begin
      m_axis_tid                <= s_axis_tid;
      m_axis_tuser_dst          <= s_axis_tuser_dst;
      m_axis_tuser_src          <= s_axis_tuser_src;
      m_axis_tuser_bypass_all   <= s_axis_tuser_bypass_all;
      m_axis_tuser_bypass_stage <= s_axis_tuser_bypass_stage;
      rd_en                     <= en_vec[s_axis_tid[AW-1:0]] && tid_ok;
      rd_ctr                    <= ctr_mem[s_axis_tid[AW-1:0]];
      rd_rx                     <= rx_mem[s_axis_tid[AW-1:0]];
    end else if (state == S_LOOKUP) begin
      m_axis_tuser_nonce  <= byp ? 64'd0 : rd_ctr;
      m_axis_tuser_rx_idx <= byp ? 32'd0 : rd_rx;
    end
  end

  // Config writes arriving mid-packet are parked until the FSM is back in IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      pend_peer <= '0;
      pend_rx   <= '0;
      pend_en   <= 1'b0;
    end else if (cfg_we && (state != S_IDLE || pend)) begin
      pend      <= 1'b1;
      pend_peer <= cfg_peer;
      pend_rx   <= cfg_rx_idx;
      pend_en   <= cfg_en;
    end else if (state == S_IDLE) begin
      pend      <= 1'b0;
    end
  end

  // Config acknowledge pulse and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_ack       <= 1'b0;
      stat_drop_cnt <= '0;
    end else begin
      cfg_ack <= cfg_fire;
      if (state == S_LOOKUP && !byp && reject && stat_drop_cnt != 32'hFFFF_FFFF)
        stat_drop_cnt <= stat_drop_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_dpe_egress_peer_nonce.sv
// Scoreboard bench for dpe_egress_peer_nonce (built with REJECT_AFTER=3 to reach exhaustion quickly).
module tb_dpe_egress_peer_nonce;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_axis_tvalid, s_axis_tready;
  logic [127:0] s_axis_tdata;
  logic [15:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic [7:0]   s_axis_tid;
  logic [2:0]   s_axis_tuser_dst, s_axis_tuser_src;
  logic         s_axis_tuser_bypass_all, s_axis_tuser_bypass_stage;
  logic         m_axis_tvalid, m_axis_tready;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic [7:0]   m_axis_tid;
  logic [2:0]   m_axis_tuser_dst, m_axis_tuser_src;
  logic         m_axis_tuser_bypass_all, m_axis_tuser_bypass_stage;
  logic [63:0]  m_axis_tuser_nonce;
  logic [31:0]  m_axis_tuser_rx_idx;
  logic         cfg_we;
  logic [7:0]   cfg_peer;
  logic [31:0]  cfg_rx_idx;
  logic         cfg_en;
  logic         cfg_ack;
  logic [31:0]  stat_drop_cnt;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
    logic [7:0]   tid;
    logic [2:0]   dst;
    logic [2:0]   src;
    logic         ba;
    logic         bs;
    logic [63:0]  nonce;
    logic [31:0]  rx;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  int    pkt_id = 0;
  logic  rnd_rdy = 1'b0;
  logic  pkt_done;

  dpe_egress_peer_nonce #(.NUM_PEERS(256), .REJECT_AFTER(64'd3)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tid(s_axis_tid), .s_axis_tuser_dst(s_axis_tuser_dst), .s_axis_tuser_src(s_axis_tuser_src),
    .s_axis_tuser_bypass_all(s_axis_tuser_bypass_all), .s_axis_tuser_bypass_stage(s_axis_tuser_bypass_stage),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tid(m_axis_tid), .m_axis_tuser_dst(m_axis_tuser_dst), .m_axis_tuser_src(m_axis_tuser_src),
    .m_axis_tuser_bypass_all(m_axis_tuser_bypass_all), .m_axis_tuser_bypass_stage(m_axis_tuser_bypass_stage),
    .m_axis_tuser_nonce(m_axis_tuser_nonce), .m_axis_tuser_rx_idx(m_axis_tuser_rx_idx),
    .cfg_we(cfg_we), .cfg_peer(cfg_peer), .cfg_rx_idx(cfg_rx_idx), .cfg_en(cfg_en),
    .cfg_ack(cfg_ack), .stat_drop_cnt(stat_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Downstream ready: always 1, or a coin flip each cycle when rnd_rdy is set
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: every accepted output beat must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      beat_t got, e;
      got = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tuser_dst,
              m_axis_tuser_src, m_axis_tuser_bypass_all, m_axis_tuser_bypass_stage,
              m_axis_tuser_nonce, m_axis_tuser_rx_idx};
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_beat: got %h expected no beat", got);
      end else begin
        e = exp_q.pop_front();
        if (got === e) n_pass++;
        else $display("FAIL beat: got %h expected %h", got, e);
      end
    end
  end

  // Drive one packet; push its beats to the scoreboard when it is expected downstream
  task automatic send_pkt(input logic [7:0] tid, input int nb, input logic bs,
                          input logic fwd, input logic [63:0] nonce, input logic [31:0] rx);
    int  t;
    logic ok;
    beat_t e;
    ok = 1'b1;
    pkt_id++;
    for (int b = 0; b < nb; b++) begin
      e.d     = {tid, 8'(b), 16'(pkt_id), 96'hC0DE_F00D_1234_5678_9ABC_0000 | 96'(b * 7)};
      e.k     = (b == nb - 1) ? 16'h00FF : 16'hFFFF;
      e.l     = (b == nb - 1);
      e.tid   = tid;
      e.dst   = tid[2:0];
      e.src   = 3'(pkt_id);
      e.ba    = 1'b0;
      e.bs    = bs;
      e.nonce = nonce;
      e.rx    = rx;
      if (fwd) exp_q.push_back(e);
    end
    for (int b = 0; b < nb && ok; b++) begin
      s_axis_tvalid             = 1'b1;
      s_axis_tdata              = {tid, 8'(b), 16'(pkt_id), 96'hC0DE_F00D_1234_5678_9ABC_0000 | 96'(b * 7)};
      s_axis_tkeep              = (b == nb - 1) ? 16'h00FF : 16'hFFFF;
      s_axis_tlast              = (b == nb - 1);
      s_axis_tid                = tid;
      s_axis_tuser_dst          = tid[2:0];
      s_axis_tuser_src          = 3'(pkt_id);
      s_axis_tuser_bypass_all   = 1'b0;
      s_axis_tuser_bypass_stage = bs;
      t = 0;
      @(negedge clk);
      while (!s_axis_tready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!s_axis_tready) ok = 1'b0;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    check("pkt_accepted", 128'(ok), 128'd1);
  endtask

  // Context write with immediate-ack checks (only valid while the FSM is idle)
  task automatic cfg_write(input logic [7:0] peer, input logic [31:0] rx, input logic en);
    cfg_we = 1'b1; cfg_peer = peer; cfg_rx_idx = rx; cfg_en = en;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_ack_pulse", 128'(cfg_ack), 128'd1);
    @(posedge clk); #1;
    check("cfg_ack_low", 128'(cfg_ack), 128'd0);
  endtask

  initial begin
    rst = 1'b1;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    s_axis_tid = '0; s_axis_tuser_dst = '0; s_axis_tuser_src = '0;
    s_axis_tuser_bypass_all = 1'b0; s_axis_tuser_bypass_stage = 1'b0;
    cfg_we = 1'b0; cfg_peer = '0; cfg_rx_idx = '0; cfg_en = 1'b0;
    pkt_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", 128'(m_axis_tvalid), 128'd0);
    check("rst_s_tready", 128'(s_axis_tready), 128'd0);
    check("rst_cfg_ack", 128'(cfg_ack), 128'd0);
    check("rst_drop_cnt", 128'(stat_drop_cnt), 128'd0);
    check("rst_nonce", 128'(m_axis_tuser_nonce), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    cfg_write(8'd5, 32'hA1B2_C3D4, 1'b1);
    send_pkt(8'd5, 1, 1'b0, 1'b1, 64'd0, 32'hA1B2_C3D4);
    send_pkt(8'd5, 2, 1'b0, 1'b1, 64'd1, 32'hA1B2_C3D4);
    send_pkt(8'd5, 3, 1'b0, 1'b1, 64'd2, 32'hA1B2_C3D4);

    send_pkt(8'd9, 4, 1'b0, 1'b0, 64'd0, 32'd0);
    check("drop_cnt_disabled", 128'(stat_drop_cnt), 128'd1);

    send_pkt(8'd5, 2, 1'b0, 1'b0, 64'd0, 32'd0);
    send_pkt(8'd5, 1, 1'b0, 1'b0, 64'd0, 32'd0);
    check("drop_cnt_exhausted", 128'(stat_drop_cnt), 128'd3);

    cfg_write(8'd5, 32'hA1B2_C3D4, 1'b1);
    send_pkt(8'd5, 2, 1'b1, 1'b1, 64'd0, 32'd0);
    send_pkt(8'd5, 2, 1'b0, 1'b1, 64'd0, 32'hA1B2_C3D4);

    rnd_rdy = 1'b1;
    send_pkt(8'd5, 10, 1'b0, 1'b1, 64'd1, 32'hA1B2_C3D4);
    rnd_rdy = 1'b0;

    fork
      begin
        send_pkt(8'd5, 3, 1'b0, 1'b1, 64'd2, 32'hA1B2_C3D4);
        pkt_done = 1'b1;
      end
      begin
        int t;
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_peer = 8'd5; cfg_rx_idx = 32'h5EED_0001; cfg_en = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        check("cfg_ack_held_off", 128'(cfg_ack), 128'd0);
        t = 0;
        while (!cfg_ack && t < 100) begin
          @(posedge clk); #1;
          t++;
        end
        check("cfg_ack_after_pkt", 128'({cfg_ack, pkt_done}), 128'b11);
      end
    join
    send_pkt(8'd5, 1, 1'b0, 1'b1, 64'd0, 32'h5EED_0001);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    check("drop_cnt_final", 128'(stat_drop_cnt), 128'd3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
